pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//   Controller that sequences the program counter for the single-cycle MIPS core.
//   Selects next PC from sequential, branch, jump and jump-register sources.
//   Applies stall hold, checks instruction-memory bounds and alignment, and halts on fault.
//   Drives the PC register path and the imem fetch address; decode/ALU feed redirects back in.
// PARAMETERS
//   RESET_PC    32'h0000_0000  first fetch address after reset
//   IMEM_BYTES  32768          instruction memory size in bytes (8192 words); legal PC < IMEM_BYTES
// PORTS
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   stall          in   1   hold current PC this cycle (hazard unit)
//   branch_taken   in   1   conditional branch resolved taken
//   branch_offset  in   32  sign-extended word offset (imm16 sign-extended)
//   jump           in   1   J/JAL
//   jump_target    in   26  instr[25:0]
//   jr             in   1   JR/JALR
//   jr_addr        in   32  register value for JR
//   pc             out  32  current fetch address
//   pc_plus4       out  32  pc + 4 (for JAL link and branch base)
//   pc_valid       out  1   pc holds a fetchable address this cycle
//   halted         out  1   sequencer in HALT
//   fault          out  2   00 none, 01 out of range, 10 misaligned, 11 reserved (never driven)
//   instr_count    out  32  count of cycles with pc_valid=1 and stall=0 (wraps at 2^32)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=BOOT, pc=RESET_PC, pc_plus4=RESET_PC+4, pc_valid=0,
//     halted=0, fault=00, instr_count=0. Reset mid-run or in HALT restores all of the above.
//   FSM states BOOT, RUN, HALT (2-bit encoding; any illegal encoding behaves as BOOT):
//     BOOT: one cycle; pc stays RESET_PC; next edge -> RUN, pc_valid=1. Redirect inputs ignored.
//     RUN: on each edge with stall=0, pc <= target, where target has priority
//       jr > jump > branch_taken > sequential:
//         jr:     target = jr_addr
//         jump:   target = {pc_plus4[31:28], jump_target, 2'b00}
//         branch: target = pc_plus4 + (branch_offset << 2), 32-bit wraparound, no overflow flag
//         else:   target = pc_plus4
//       pc_plus4 <= target + 4 (registered with pc; never combinational from inputs).
//       stall=1: pc, pc_plus4 and instr_count hold; all redirect inputs ignored this cycle.
//         Upstream holds redirects until stall drops. stall has priority over every redirect.
//     Fault check is on the selected target, in the same cycle:
//       target[1:0] != 0 -> fault=10 (checked first)
//       else target >= IMEM_BYTES -> fault=01
//       On fault: pc does not update, next state=HALT, halted=1, pc_valid=0.
//     HALT: pc, pc_plus4, fault and instr_count frozen; all inputs ignored; exit only via rst_n.
//   instr_count increments on edges in RUN with stall=0, whether or not the step faults.
//   Latency: redirect sampled at edge N is visible on pc after edge N (one cycle).
//   Address math is unsigned 32-bit. Sequential step from pc=IMEM_BYTES-4 yields target=IMEM_BYTES,
//     which faults with 01. PC never wraps silently.
//   Simultaneous jr+jump+branch_taken: jr wins; the losing inputs have no side effects.
//   Simulation only: no $stop/$finish. The bench detects halted.
// TESTING
//   1 Reset release, no redirects, 4 cycles -> pc 0 (BOOT), 0, 4, 8; pc_valid 0,1,1,1; count=2.
//   2 pc=0x10, branch_taken=1, offset=-2 -> pc=0x0C, pc_plus4=0x10; offset=0x1FFF from 0 -> fault 01.
//   3 jr=1, jump=1, branch_taken=1 together, jr_addr=0x40 -> pc=0x40; jr_addr=0x42 -> fault=10, halted=1.
//   4 stall=1 for 3 cycles with jump pending -> pc, count frozen; stall=0 -> pc=jump target next edge.
//   5 Sequential run to pc=0x7FFC, one more edge -> fault=01, pc stays 0x7FFC, later inputs ignored.
//   6 Assert rst_n=0 asynchronously mid-cycle in HALT and in RUN -> outputs at reset values immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for the single-cycle MIPS core. It picks the
//   next fetch address from four sources, in priority order: jump-register,
//   jump, taken branch, then the sequential pc+4. It holds the PC while the
//   hazard unit stalls. It checks every selected target for word alignment and
//   for instruction-memory bounds. On a bad target it halts, and only rst_n
//   can bring it out of the halt.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   stall          hold current PC this cycle
//   branch_taken   conditional branch resolved taken
//   branch_offset  sign-extended word offset
//   jump           J/JAL redirect
//   jump_target    instr[25:0] of the jump
//   jr             JR/JALR redirect
//   jr_addr        register value for JR
//   pc             current fetch address
//   pc_plus4       pc + 4, registered alongside pc
//   pc_valid       pc holds a fetchable address
//   halted         sequencer stopped on a fault
//   fault          00 none, 01 out of range, 10 misaligned
//   instr_count    cycles spent in RUN without a stall (wraps)
// ---------------------------------------------------------------------------
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 32768
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        pc_valid,
   output logic        halted,
   output logic [1:0]  fault,
   output logic [31:0] instr_count
);

   localparam logic [1:0] ST_BOOT = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_HALT = 2'b10;

   localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

   localparam logic [1:0] FAULT_NONE  = 2'b00;
   localparam logic [1:0] FAULT_RANGE = 2'b01;
   localparam logic [1:0] FAULT_ALIGN = 2'b10;

   logic [1:0]  state_r;
   logic [31:0] pc_r;
   logic [31:0] pc_plus4_r;
   logic        pc_valid_r;
   logic        halted_r;
   logic [1:0]  fault_r;
   logic [31:0] instr_count_r;

   logic [31:0] jump_tgt_s;
   logic [31:0] branch_tgt_s;
   logic [31:0] target_s;
   logic [1:0]  fault_s;

   // Next-PC selection and fault classification of the selected target.
   always_comb begin
      jump_tgt_s   = {pc_plus4_r[31:28], jump_target, 2'b00};
      branch_tgt_s = pc_plus4_r + (branch_offset << 2);
      target_s     = pc_plus4_r;
      fault_s      = FAULT_NONE;
      if (jr) begin
         target_s = jr_addr;
      end else if (jump) begin
         target_s = jump_tgt_s;
      end else if (branch_taken) begin
         target_s = branch_tgt_s;
      end else begin
         target_s = pc_plus4_r;
      end
      // Misalignment outranks range so a misaligned out-of-range target reports 10.
      if (target_s[1:0] != 2'b00) begin
         fault_s = FAULT_ALIGN;
      end else if (target_s >= IMEM_LIMIT) begin
         fault_s = FAULT_RANGE;
      end else begin
         fault_s = FAULT_NONE;
      end
   end

   // Sequencer FSM together with the PC, status and instruction-count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_BOOT;
         pc_r          <= RESET_PC;
         pc_plus4_r    <= RESET_PC + 32'd4;
         pc_valid_r    <= 1'b0;
         halted_r      <= 1'b0;
         fault_r       <= FAULT_NONE;
         instr_count_r <= 32'd0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (!stall) begin
                  // A faulting step is still a counted cycle.
                  instr_count_r <= instr_count_r + 32'd1;
                  if (fault_s != FAULT_NONE) begin
                     state_r    <= ST_HALT;
                     halted_r   <= 1'b1;
                     pc_valid_r <= 1'b0;
                     fault_r    <= fault_s;
                  end else begin
                     pc_r       <= target_s;
                     pc_plus4_r <= target_s + 32'd4;
                  end
               end else begin
                  pc_r <= pc_r;
               end
            end
            ST_HALT: begin
               state_r <= ST_HALT;
            end
            default: begin
               // BOOT, and any corrupted encoding, restarts cleanly into RUN.
               state_r       <= ST_RUN;
               pc_r          <= RESET_PC;
               pc_plus4_r    <= RESET_PC + 32'd4;
               pc_valid_r    <= 1'b1;
               halted_r      <= 1'b0;
               fault_r       <= FAULT_NONE;
            end
         endcase
      end
   end

   assign pc          = pc_r;
   assign pc_plus4    = pc_plus4_r;
   assign pc_valid    = pc_valid_r;
   assign halted      = halted_r;
   assign fault       = fault_r;
   assign instr_count = instr_count_r;

endmodule
